// File: rtl/dp_ram_arb_pkg.sv
// Shared types and constants for the dual-port RAM port-B arbiter.
package dp_ram_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;

    localparam logic [BE_W-1:0] BE_FULL = 4'hF;

    typedef enum logic {
        ARB       = 1'b0,
        RMW_MERGE = 1'b1
    } state_e;

    typedef logic req_idx_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } rsp_kind_e;

endpackage

// File: rtl/dp_ram_rr_arb.sv
// Two-way round-robin grant with its priority pointer; i_en low blocks all grants.
module dp_ram_rr_arb
    import dp_ram_arb_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt_c,
    output req_idx_t           o_idx_c
);

    req_idx_t r_ptr;

    always_comb begin
        o_gnt_c = '0;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt_c = 2'b01;
                2'b10:   o_gnt_c = 2'b10;
                2'b11:   o_gnt_c = r_ptr ? 2'b10 : 2'b01;
                default: o_gnt_c = '0;
            endcase
        end
        o_idx_c = req_idx_t'(o_gnt_c[1]);
    end

    // Pointer hands priority to the requester that did not just win.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (|o_gnt_c) begin
            r_ptr <= ~o_idx_c;
        end
    end

endmodule

// File: rtl/dp_ram_port_arbiter.sv
// Shares RAM port B between two OBI-style requesters; sub-word writes become
// a read in the grant cycle followed by a merged full-word write.
module dp_ram_port_arbiter
    import dp_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_i,
    output logic [NUM_REQ-1:0]                   gnt_o,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]                   we_i,
    input  logic [NUM_REQ-1:0][BE_W-1:0]         be_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]       wdata_i,
    output logic [NUM_REQ-1:0]                   rvalid_o,
    output logic [NUM_REQ-1:0][DATA_W-1:0]       rdata_o,
    output logic                                 mem_en_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    output logic [DATA_W-1:0]                    mem_wdata_o,
    input  logic [DATA_W-1:0]                    mem_rdata_i
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic                    w_arb_en;
    logic [NUM_REQ-1:0]      w_gnt;
    logic                    w_gnt_any;
    req_idx_t                w_idx;
    logic [ADDR_WIDTH-1:0]   w_word_addr;
    logic                    w_latch;
    req_idx_t                r_owner;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [BE_W-1:0]         r_be;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       w_merged;
    logic [NUM_REQ-1:0]      w_rvalid_nxt;
    logic [NUM_REQ-1:0]      r_rvalid;
    rsp_kind_e               w_kind_nxt;
    rsp_kind_e               r_kind;

    assign w_arb_en    = (r_state == ARB) && !rst_i;
    assign w_gnt_any   = |w_gnt;
    assign gnt_o       = w_gnt;
    assign rvalid_o    = r_rvalid;
    assign w_word_addr = addr_i[w_idx] & ~ADDR_WIDTH'(3);

    dp_ram_rr_arb u_rr_arb (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_en    (w_arb_en),
        .i_req   (req_i),
        .o_gnt_c (w_gnt),
        .o_idx_c (w_idx)
    );

    always_comb begin
        w_merged = mem_rdata_i;
        for (int b = 0; b < int'(BE_W); b++) begin
            if (r_be[b]) begin
                w_merged[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    // Next state, RAM port drive and response scheduling; all quiet in reset.
    always_comb begin
        w_state_nxt  = r_state;
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        w_rvalid_nxt = '0;
        w_kind_nxt   = READ;
        w_latch      = 1'b0;
        if (!rst_i) begin
            case (r_state)
                ARB: begin
                    if (w_gnt_any) begin
                        w_rvalid_nxt[w_idx] = 1'b1;
                        w_kind_nxt          = we_i[w_idx] ? WRITE : READ;
                        if (!we_i[w_idx]) begin
                            mem_en_o   = 1'b1;
                            mem_addr_o = w_word_addr;
                        end else if (be_i[w_idx] == BE_FULL) begin
                            mem_en_o    = 1'b1;
                            mem_we_o    = 1'b1;
                            mem_addr_o  = w_word_addr;
                            mem_wdata_o = wdata_i[w_idx];
                        end else if (be_i[w_idx] != '0) begin
                            mem_en_o     = 1'b1;
                            mem_addr_o   = w_word_addr;
                            w_latch      = 1'b1;
                            w_rvalid_nxt = '0;
                            w_state_nxt  = RMW_MERGE;
                        end
                    end
                end
                RMW_MERGE: begin
                    mem_en_o              = 1'b1;
                    mem_we_o              = 1'b1;
                    mem_addr_o            = r_addr;
                    mem_wdata_o           = w_merged;
                    w_rvalid_nxt[r_owner] = 1'b1;
                    w_kind_nxt            = WRITE;
                    w_state_nxt           = ARB;
                end
                default: w_state_nxt = ARB;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_owner <= w_idx;
            r_addr  <= w_word_addr;
            r_be    <= be_i[w_idx];
            r_wdata <= wdata_i[w_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_kind   <= READ;
        end else begin
            r_rvalid <= w_rvalid_nxt;
            r_kind   <= w_kind_nxt;
        end
    end

    // Read data arrives from the RAM in the rvalid cycle; writes answer zero.
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (r_rvalid[k] && (r_kind == READ)) begin
                rdata_o[k] = mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Directed, table-driven bench for dp_ram_port_arbiter with a word RAM model on port B.
module tb_dp_ram_port_arbiter;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [1:0][7:0]  addr;
    logic [1:0]       we;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wdata;
    logic [1:0]       rvalid;
    logic [1:0][31:0] rdata;
    logic             men;
    logic [7:0]       maddr;
    logic             mwe;
    logic [31:0]      mwdata;
    logic [31:0]      mrdata;

    logic [31:0] ram [0:63];

    int checks = 0;
    int errors = 0;

    dp_ram_port_arbiter #(.ADDR_WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .gnt_o       (gnt),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .mem_en_o    (men),
        .mem_addr_o  (maddr),
        .mem_we_o    (mwe),
        .mem_wdata_o (mwdata),
        .mem_rdata_i (mrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous word RAM: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (men) begin
            if (mwe) ram[maddr[7:2]] <= mwdata;
            mrdata <= ram[maddr[7:2]];
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic        we0;
        logic [3:0]  be0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        we1;
        logic [3:0]  be1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        men;
        logic        mwe;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [1:0] rq,
                                logic w0, logic [3:0] b0, logic [7:0] ad0, logic [31:0] dd0,
                                logic w1, logic [3:0] b1, logic [7:0] ad1, logic [31:0] dd1,
                                logic [1:0] g, logic [1:0] v, logic [31:0] r0, logic [31:0] r1,
                                logic en, logic wr);
        vec_t x;
        x.req = rq;  x.we0 = w0; x.be0 = b0; x.a0 = ad0; x.d0 = dd0;
        x.we1 = w1;  x.be1 = b1; x.a1 = ad1; x.d1 = dd1;
        x.gnt = g;   x.rv = v;   x.rd0 = r0; x.rd1 = r1;
        x.men = en;  x.mwe = wr;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        req      = v.req;
        we[0]    = v.we0; be[0] = v.be0; addr[0] = v.a0; wdata[0] = v.d0;
        we[1]    = v.we1; be[1] = v.be1; addr[1] = v.a1; wdata[1] = v.d1;
    endtask

    initial begin
        rst   = 1'b0;
        req   = 2'b11;
        we    = 2'b00;
        be    = '1;
        addr  = '0;
        wdata = '0;

        // Reset asserted mid-cycle with both requesters active.
        #3 rst = 1'b1;
        #1;
        chk("reset gnt", 32'(gnt), 32'h0);
        chk("reset mem_en", 32'(men), 32'h0);
        chk("reset mem_we", 32'(mwe), 32'h0);
        chk("reset rvalid", 32'(rvalid), 32'h0);
        chk("reset rdata0", rdata[0], 32'h0);
        chk("reset rdata1", rdata[1], 32'h0);
        chk("reset mem_addr", 32'(maddr), 32'h0);
        chk("reset mem_wdata", mwdata, 32'h0);
        req = 2'b00;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;

        //          req    we0 be0   a0     d0            we1 be1   a1     d1            gnt    rv     rd0           rd1           en wr
        vt.push_back(mk(2'b10, 0, 4'h0, 8'h00, 32'h0,        1, 4'hF, 8'h10, 32'hDEADBEEF, 2'b10, 2'b00, 32'h0,        32'h0,        1, 1));
        vt.push_back(mk(2'b10, 0, 4'h0, 8'h00, 32'h0,        1, 4'hF, 8'h20, 32'hCAFEF00D, 2'b10, 2'b10, 32'h0,        32'h0,        1, 1));
        vt.push_back(mk(2'b10, 0, 4'h0, 8'h00, 32'h0,        1, 4'hF, 8'h30, 32'h01234567, 2'b10, 2'b10, 32'h0,        32'h0,        1, 1));
        vt.push_back(mk(2'b10, 0, 4'h0, 8'h00, 32'h0,        1, 4'hF, 8'h40, 32'h89ABCDEF, 2'b10, 2'b10, 32'h0,        32'h0,        1, 1));
        vt.push_back(mk(2'b11, 0, 4'hF, 8'h10, 32'h0,        0, 4'hF, 8'h20, 32'h0,        2'b01, 2'b10, 32'h0,        32'h0,        1, 0));
        vt.push_back(mk(2'b11, 0, 4'hF, 8'h30, 32'h0,        0, 4'hF, 8'h20, 32'h0,        2'b10, 2'b01, 32'hDEADBEEF, 32'h0,        1, 0));
        vt.push_back(mk(2'b11, 0, 4'hF, 8'h30, 32'h0,        0, 4'hF, 8'h40, 32'h0,        2'b01, 2'b10, 32'h0,        32'hCAFEF00D, 1, 0));
        vt.push_back(mk(2'b11, 0, 4'hF, 8'h30, 32'h0,        0, 4'hF, 8'h40, 32'h0,        2'b10, 2'b01, 32'h01234567, 32'h0,        1, 0));
        vt.push_back(mk(2'b01, 0, 4'hF, 8'h30, 32'h0,        0, 4'hF, 8'h00, 32'h0,        2'b01, 2'b10, 32'h0,        32'h89ABCDEF, 1, 0));
        vt.push_back(mk(2'b00, 0, 4'hF, 8'h00, 32'h0,        0, 4'hF, 8'h00, 32'h0,        2'b00, 2'b01, 32'h01234567, 32'h0,        0, 0));
        vt.push_back(mk(2'b10, 0, 4'hF, 8'h00, 32'h0,        0, 4'hF, 8'h10, 32'h0,        2'b10, 2'b00, 32'h0,        32'h0,        1, 0));
        vt.push_back(mk(2'b11, 1, 4'h5, 8'h12, 32'h11223344, 0, 4'hF, 8'h20, 32'h0,        2'b01, 2'b10, 32'h0,        32'hDEADBEEF, 1, 0));
        vt.push_back(mk(2'b10, 0, 4'hF, 8'h00, 32'h0,        0, 4'hF, 8'h20, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0,        1, 1));
        vt.push_back(mk(2'b10, 0, 4'hF, 8'h00, 32'h0,        0, 4'hF, 8'h20, 32'h0,        2'b10, 2'b01, 32'h0,        32'h0,        1, 0));
        vt.push_back(mk(2'b01, 0, 4'hF, 8'h10, 32'h0,        0, 4'hF, 8'h00, 32'h0,        2'b01, 2'b10, 32'h0,        32'hCAFEF00D, 1, 0));
        vt.push_back(mk(2'b01, 1, 4'h0, 8'h20, 32'hFFFFFFFF, 0, 4'hF, 8'h00, 32'h0,        2'b01, 2'b01, 32'hDE22BE44, 32'h0,        0, 0));
        vt.push_back(mk(2'b01, 0, 4'hF, 8'h20, 32'h0,        0, 4'hF, 8'h00, 32'h0,        2'b01, 2'b01, 32'h0,        32'h0,        1, 0));
        vt.push_back(mk(2'b00, 0, 4'hF, 8'h00, 32'h0,        0, 4'hF, 8'h00, 32'h0,        2'b00, 2'b01, 32'hCAFEF00D, 32'h0,        0, 0));
        vt.push_back(mk(2'b01, 1, 4'hF, 8'h44, 32'h5A5A5A5A, 0, 4'hF, 8'h00, 32'h0,        2'b01, 2'b00, 32'h0,        32'h0,        1, 1));
        vt.push_back(mk(2'b01, 0, 4'hF, 8'h47, 32'h0,        0, 4'hF, 8'h00, 32'h0,        2'b01, 2'b01, 32'h0,        32'h0,        1, 0));
        vt.push_back(mk(2'b00, 0, 4'hF, 8'h00, 32'h0,        0, 4'hF, 8'h00, 32'h0,        2'b00, 2'b01, 32'h5A5A5A5A, 32'h0,        0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1 drive(vt[i]);
            @(negedge clk);
            chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(vt[i].gnt));
            chk($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(vt[i].rv));
            chk($sformatf("row%0d rdata0", i), rdata[0], vt[i].rd0);
            chk($sformatf("row%0d rdata1", i), rdata[1], vt[i].rd1);
            chk($sformatf("row%0d mem_en", i), 32'(men), 32'(vt[i].men));
            chk($sformatf("row%0d mem_we", i), 32'(mwe), 32'(vt[i].mwe));
        end

        // Reset during RMW_MERGE: requester 1 partial write to 0x30, abandoned.
        @(posedge clk);
        #1;
        req = 2'b10; we[1] = 1'b1; be[1] = 4'h3; addr[1] = 8'h31; wdata[1] = 32'hAAAAAAAA;
        @(negedge clk);
        chk("rmwrst gnt N", 32'(gnt), 32'h2);
        chk("rmwrst read N", 32'({men, mwe}), 32'h2);
        @(posedge clk);
        #1 req = 2'b00;
        chk("rmwrst merge active", 32'({men, mwe}), 32'h3);
        #1 rst = 1'b1;
        #1;
        chk("rmwrst mem quiet", 32'({men, mwe}), 32'h0);
        chk("rmwrst rvalid", 32'(rvalid), 32'h0);
        @(posedge clk);
        #1 chk("rmwrst no rvalid", 32'(rvalid), 32'h0);
        @(negedge clk) rst = 1'b0;

        @(posedge clk);
        #1;
        req = 2'b11; we = 2'b00; be = '1; addr[0] = 8'h30; addr[1] = 8'h40;
        @(negedge clk);
        chk("post-reset ptr gnt", 32'(gnt), 32'h1);
        chk("post-reset rvalid", 32'(rvalid), 32'h0);
        @(posedge clk);
        #1 req = 2'b10;
        @(negedge clk);
        chk("post-reset gnt1", 32'(gnt), 32'h2);
        chk("post-reset rvalid0", 32'(rvalid), 32'h1);
        chk("word 0x30 unchanged", rdata[0], 32'h01234567);
        @(posedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        chk("post-reset rvalid1", 32'(rvalid), 32'h2);
        chk("word 0x40 read", rdata[1], 32'h89ABCDEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_ram_port_arbiter.md
# dp_ram_port_arbiter

Shares the single data port (port B) of the testbench dual-port RAM between two OBI-style requesters: the core data interface (requester 0) and a testbench loader/monitor agent (requester 1). Grants are round-robin. Because the RAM port writes whole 32-bit words only, partial-byte writes are handled internally as a read-modify-write (RMW) sequence. The block sits between the requesters and the RAM port-B pins; port A (instruction fetch) is not touched.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte-address width of the RAM port; same value as the RAM instance.

Ports:
- clk_i  in  1  clock; all flops on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  [1:0]  per-requester request.
- gnt_o  out  [1:0]  per-requester grant; combinational, at most one bit set.
- addr_i  in  [1:0][ADDR_WIDTH-1:0]  per-requester byte address.
- we_i  in  [1:0]  per-requester write enable.
- be_i  in  [1:0][3:0]  per-requester byte enables.
- wdata_i  in  [1:0][31:0]  per-requester write data.
- rvalid_o  out  [1:0]  per-requester response valid; registered.
- rdata_o  out  [1:0][31:0]  per-requester read data; zero when that requester's rvalid_o is 0.
- mem_en_o  out  1  RAM port-B enable.
- mem_addr_o  out  ADDR_WIDTH  RAM address; bits [1:0] are always 0.
- mem_we_o  out  1  RAM write enable.
- mem_wdata_o  out  32  RAM write data (full word).
- mem_rdata_i  in  32  RAM read data; valid in the cycle after a read is issued.

## Operation
- FSM states: ARB, RMW_MERGE.
- ARB state:
  - If one or more req_i bits are set, grant exactly one requester. On contention the winner is the requester selected by the priority pointer.
  - After each grant, the pointer moves to the other requester.
- Transaction classes, decided at the grant:
  - Read: issue a RAM read in the grant cycle.
  - Full write (be=4'hF): issue a RAM write of wdata in the grant cycle.
  - Null write (be=4'h0): no RAM access; respond only.
  - Partial write (any other be):
    - Issue a RAM read in the grant cycle.
    - Latch owner, word address, be and wdata; go to RMW_MERGE.
- RMW_MERGE state:
  - gnt_o=0.
  - Issue a RAM write to the latched address. Each byte lane is the latched wdata where be=1, otherwise the mem_rdata_i byte.
  - Return to ARB.
- Responses:
  - Read: rdata_o = mem_rdata_i in the rvalid cycle.
  - Write: rdata_o = 0.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; FSM=ARB; pointer=requester 0.
- Reset mid-RMW: the sequence is abandoned, no RAM write occurs, and no rvalid is produced.
- Address bits [1:0] are ignored for addressing; byte lanes are selected by be only.

## Timing
- The grant is in the same cycle as req (cycle N). Request fields are sampled only in cycle N.
- Read, full write, null write:
  - RAM access in cycle N.
  - rvalid_o in cycle N+1.
  - Back-to-back grants every cycle are allowed.
- Partial write:
  - RAM read in cycle N; merged write in cycle N+1.
  - rvalid_o in cycle N+2.
  - No grant in cycle N+1. The next grant is possible in cycle N+2.
- A requester that is not granted keeps req_i high with stable fields until granted.
- rvalid_o is a one-cycle pulse per granted transaction, in grant order.
- Both rvalid_o bits are never set in the same cycle.

## Structure
- Package dp_ram_arb_pkg holds:
  - the FSM state enum (ARB, RMW_MERGE);
  - the requester-index typedef;
  - the response-kind enum (READ, WRITE);
  - the localparam BE_FULL=4'hF.
- Sub-module dp_ram_rr_arb: the 2-way round-robin grant logic plus its pointer flop, with an enable input that blocks grants while in RMW_MERGE.
- The top level holds the FSM, RMW latches, byte merge, RAM muxing, and response flops.

## Test plan
- Reset: assert rst_i mid-cycle with req_i=2'b11 → all outputs 0 immediately; pointer=requester 0 after release.
- Contention: req_i=2'b11 held for 4 reads → gnt_o sequence 01,10,01,10; each rvalid_o follows one cycle after its grant, with the correct word.
- Partial write: word 0x10 preloaded to 0xDEADBEEF; requester 0 writes be=4'b0101, wdata=0x11223344, addr=0x12 → gnt at N, no gnt at N+1, rvalid at N+2; a subsequent read of 0x10 returns 0xDE22BE44.
- Blocking during RMW: partial write from requester 0 while requester 1 is requesting → requester 1 is granted at N+2, not N+1.
- Null write: be=4'h0 to 0x20 → mem_en_o=0, rvalid at N+1, memory word unchanged.
- Reset in RMW_MERGE: assert rst_i in cycle N+1 of a partial write → no RAM write, no rvalid; the word at that address reads back unchanged.
